prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 29 ++
 rtl/byte_asm.sv | 42 ++++
 rtl/prog_loader.sv | 168 ++++++++++++++++
 tb/tb_prog_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// The CSUM state exists only when PROG_LOADER_CSUM_EN is defined.
package loader_pkg;

  localparam int unsigned HdrFieldBytes = 4;
  localparam int unsigned WordBytes     = 4;

`ifdef PROG_LOADER_CSUM_EN
  typedef enum logic [2:0] {
    StHdrAddr,
    StHdrLen,
    StData,
    StWrite,
    StCsum,
    StDone,
    StErr
  } state_e;
`else
  typedef enum logic [2:0] {
    StHdrAddr,
    StHdrLen,
    StData,
    StWrite,
    StDone,
    StErr
  } state_e;
`endif

endpackage

// File: rtl/byte_asm.sv
// Assembles little-endian bytes into a 32-bit word; word_o already includes the
// byte being accepted this cycle so a completed field can be consumed on last_o.
module byte_asm
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic [1:0]  idx_o,
  output logic        last_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  always_comb begin
    word_o = word_q;
    if (en_i) begin
      word_o[{idx_q, 3'b000} +: 8] = data_i;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = en_i && (idx_q == 2'(WordBytes - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clr_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (en_i) begin
      word_q <= word_o;
      idx_q  <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a {base, count, payload} image into core memory while holding the core in reset.
// Define PROG_LOADER_CSUM_EN to require a trailing XOR checksum byte after the payload.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        restart,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        hold,
  output logic        done,
  output logic        err
);

`ifdef PROG_LOADER_CSUM_EN
  localparam state_e StPayloadEnd = StCsum;
`else
  localparam state_e StPayloadEnd = StDone;
`endif

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] len_q, len_d;
  logic [31:0] cnt_q, cnt_d;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept, asm_en, asm_clr, asm_last, fits;
  logic [31:0] asm_word;
  logic [1:0]  asm_idx;
  logic [34:0] end_addr;
  logic        unused_asm_idx;

`ifdef PROG_LOADER_CSUM_EN
  assign in_ready = (state_q == StHdrAddr) || (state_q == StHdrLen) ||
                    (state_q == StData) || (state_q == StCsum);
  assign asm_en   = accept && (state_q != StCsum);
`else
  assign in_ready = (state_q == StHdrAddr) || (state_q == StHdrLen) || (state_q == StData);
  assign asm_en   = accept;
`endif
  assign accept   = in_valid && in_ready;
  assign asm_clr  = restart && ((state_q == StDone) || (state_q == StErr));

  // Wide enough that base + 4*N can never wrap.
  assign end_addr = {3'b000, base_q} + {1'b0, asm_word, 2'b00};
  assign fits     = end_addr <= 35'(MEM_BYTES);
  assign unused_asm_idx = ^asm_idx;

  byte_asm u_byte_asm (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (asm_clr),
    .en_i   (asm_en),
    .data_i (in_data),
    .word_o (asm_word),
    .idx_o  (asm_idx),
    .last_o (asm_last)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
`ifdef PROG_LOADER_CSUM_EN
    csum_d    = csum_q;
`endif
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    hold      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      StHdrAddr: begin
        if (asm_last) begin
          base_d  = asm_word;
          state_d = (asm_word[1:0] != 2'b00) ? StErr : StHdrLen;
        end
      end
      StHdrLen: begin
        if (asm_last) begin
          len_d = asm_word;
          cnt_d = '0;
          if (asm_word == '0) begin
            state_d = StPayloadEnd;
          end else if (!fits) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
`ifdef PROG_LOADER_CSUM_EN
        if (accept) begin
          csum_d = csum_q ^ in_data;
        end
`endif
        if (asm_last) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        mem_wen   = 1'b1;
        mem_addr  = base_q + (cnt_q << 2);
        mem_wdata = asm_word;
        cnt_d     = cnt_q + 32'd1;
        state_d   = ((cnt_q + 32'd1) < len_q) ? StData : StPayloadEnd;
      end
`ifdef PROG_LOADER_CSUM_EN
      StCsum: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? StDone : StErr;
        end
      end
`endif
      StDone: begin
        hold = 1'b0;
        done = 1'b1;
      end
      StErr: begin
        err = 1'b1;
      end
      default: state_d = StHdrAddr;
    endcase

    if (asm_clr) begin
      state_d = StHdrAddr;
      base_d  = '0;
      len_d   = '0;
      cnt_d   = '0;
`ifdef PROG_LOADER_CSUM_EN
      csum_d  = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StHdrAddr;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
`ifdef PROG_LOADER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
`ifdef PROG_LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected writes go into a queue that a
// negedge monitor drains; status flags are checked at the end of each load.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        restart;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        hold;
  logic        done;
  logic        err;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad   = 0;

  prog_loader #(.MEM_BYTES(4096)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .restart   (restart),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .hold      (hold),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (mem_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write",
                   mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", mem_addr, mon_e.a);
          chk("wr_data", mem_wdata, mon_e.d);
        end
      end else begin
        chk("idle_addr", mem_addr, 32'h0);
        chk("idle_data", mem_wdata, 32'h0);
      end
    end
  end

  function automatic logic [7:0] xor4(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      ok = in_ready;
      tick();
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for byte %h", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], rnd ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  task automatic send_csum(input logic [7:0] c);
`ifdef PROG_LOADER_CSUM_EN
    send_byte(c, 0);
`else
    in_data = c;
`endif
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic wait_end(input string name, input logic exp_done);
    int n = 0;
    while (!(done || err) && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk({name, "_done"}, 32'(done), 32'(exp_done));
    chk({name, "_err"}, 32'(err), 32'(!exp_done));
    chk({name, "_hold"}, 32'(hold), 32'(!exp_done));
    chk({name, "_in_ready"}, 32'(in_ready), 32'h0);
    chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    restart  = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_hold", 32'(hold), 32'h1);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_wen", 32'(mem_wen), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    reset = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Two-word image at 0x100.
    expect_wr(32'h100, 32'h0000_0013);
    expect_wr(32'h104, 32'h0010_0073);
    send_word(32'h100, 0);
    send_word(32'h2, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0073, 0);
    send_csum(8'h70);
    wait_end("basic", 1'b1);

    do_restart();
    chk("restart_in_ready", 32'(in_ready), 32'h1);
    chk("restart_done", 32'(done), 32'h0);
    chk("restart_hold", 32'(hold), 32'h1);

    // Misaligned base.
    send_word(32'h0000_0102, 0);
    wait_end("misaligned", 1'b0);
    do_restart();
    chk("restart_err", 32'(err), 32'h0);

    // Bounds at the top of memory.
    send_word(32'hFFC, 0);
    send_word(32'h2, 0);
    wait_end("overflow", 1'b0);
    do_restart();
    expect_wr(32'hFFC, 32'hDEAD_BEEF);
    send_word(32'hFFC, 0);
    send_word(32'h1, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_csum(xor4(32'hDEAD_BEEF));
    wait_end("top_word", 1'b1);

    // Empty image.
    do_restart();
    send_word(32'h40, 0);
    send_word(32'h0, 0);
    send_csum(8'h00);
    wait_end("empty", 1'b1);

    // Gappy stream with a restart pulse mid-header that must be ignored.
    do_restart();
    expect_wr(32'h100, 32'h0000_0013);
    expect_wr(32'h104, 32'h0010_0073);
    send_word(32'h100, 1);
    do_restart();
    chk("ignored_restart_ready", 32'(in_ready), 32'h1);
    send_word(32'h2, 1);
    send_word(32'h0000_0013, 1);
    send_word(32'h0010_0073, 1);
    send_csum(8'h70);
    wait_end("gappy", 1'b1);

    // Reset mid-word discards the partial load.
    do_restart();
    send_word(32'h200, 0);
    send_word(32'h1, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b0;
    #2;
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    chk("midrst_hold", 32'(hold), 32'h1);
    chk("midrst_wen", 32'(mem_wen), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    expect_wr(32'h300, 32'h1122_3344);
    send_word(32'h300, 0);
    send_word(32'h1, 0);
    send_word(32'h1122_3344, 0);
    send_csum(xor4(32'h1122_3344));
    wait_end("after_reset", 1'b1);

`ifdef PROG_LOADER_CSUM_EN
    do_restart();
    expect_wr(32'h0, 32'h0000_0013);
    send_word(32'h0, 0);
    send_word(32'h1, 0);
    send_word(32'h0000_0013, 0);
    send_byte(8'h13, 0);
    wait_end("csum_good", 1'b1);
    do_restart();
    expect_wr(32'h0, 32'h0000_0013);
    send_word(32'h0, 0);
    send_word(32'h1, 0);
    send_word(32'h0000_0013, 0);
    send_byte(8'h00, 0);
    wait_end("csum_bad", 1'b0);
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
